// File: rtl/tpu_control_if.sv
// ---------------------------------------------------------------------------
// tpu_control_if
//
// Bundles every non-clock signal of the TPU controller: the host byte stream
// in and out, the operand-memory write port, and the matrix-unit control and
// result-select lines.
//
// Modports
//   master : host / environment side (drives in_valid, in_data, out_ready,
//            res_data; observes everything the controller produces)
//   slave  : the controller itself (tpu_control)
//
// Signals
//   in_valid / in_data / in_ready     host byte stream into the controller
//   mem_write_en / mem_addr / mem_in_data  operand memory write port
//   mmu_start / mmu_clear             matrix unit control pulses
//   res_sel / res_data                matrix unit result element select/read
//   out_valid / out_data / out_ready  result byte stream back to the host
//   busy / done                       status
// ---------------------------------------------------------------------------
interface tpu_control_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write_en;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_in_data;
    logic        mmu_start;
    logic        mmu_clear;
    logic [1:0]  res_sel;
    logic [15:0] res_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output in_valid,
        output in_data,
        output res_data,
        output out_ready,
        input  in_ready,
        input  mem_write_en,
        input  mem_addr,
        input  mem_in_data,
        input  mmu_start,
        input  mmu_clear,
        input  res_sel,
        input  out_valid,
        input  out_data,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  res_data,
        input  out_ready,
        output in_ready,
        output mem_write_en,
        output mem_addr,
        output mem_in_data,
        output mmu_start,
        output mmu_clear,
        output res_sel,
        output out_valid,
        output out_data,
        output busy,
        output done
    );
endinterface

// File: rtl/tpu_control.sv
// ---------------------------------------------------------------------------
// tpu_control
//
// Sequencer for a small matrix unit. One transaction:
//   LOAD    : accept 8 host bytes (4 weights, then 4 inputs) and write each
//             straight into operand memory at address 0..7 in the cycle it
//             is accepted.
//   COMPUTE : pulse mmu_start on the first cycle, then wait COMPUTE_CYCLES
//             cycles in total for the matrix unit.
//   DRAIN   : stream the four 16-bit results back as 8 bytes, element 0
//             first, low byte before high byte, under out_valid/out_ready.
// Accepting the last result byte returns to LOAD and pulses done and
// mmu_clear for one cycle; a new byte may be accepted in that same cycle.
//
// Parameters
//   COMPUTE_CYCLES : length of the COMPUTE phase in cycles (1..255)
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset; while high all handshake and
//         strobe outputs are forced low and any partial load is dropped
//   bus : tpu_control_if.slave, all data/handshake/status signals
// ---------------------------------------------------------------------------
module tpu_control #(
    parameter int COMPUTE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    tpu_control_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // ccnt value seen in the final COMPUTE cycle.
    localparam logic [7:0] LP_CCNT_LAST = 8'(COMPUTE_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_lcnt;
    logic [7:0]  r_ccnt;
    logic [2:0]  r_dcnt;
    logic        r_mmu_start;
    logic        r_mmu_clear;
    logic        r_done;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_valid;
    logic        w_transfer;
    logic [7:0]  w_res_byte;

    // The state register already resets asynchronously, but gating with rst
    // keeps the handshakes low for the whole reset window, not just after
    // the reset has propagated through the flops.
    assign w_in_ready  = (r_state == ST_LOAD) && !rst;
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_out_valid = (r_state == ST_DRAIN) && !rst;
    assign w_transfer  = w_out_valid && bus.out_ready;

    // dcnt[0] picks the byte lane, dcnt[2:1] the result element.
    assign w_res_byte  = r_dcnt[0] ? bus.res_data[15:8] : bus.res_data[7:0];

    assign bus.in_ready     = w_in_ready;
    assign bus.mem_write_en = w_accept;
    assign bus.mem_addr     = (r_state == ST_LOAD) ? r_lcnt : 3'd0;
    assign bus.mem_in_data  = bus.in_data;
    assign bus.mmu_start    = r_mmu_start;
    assign bus.mmu_clear    = r_mmu_clear;
    assign bus.res_sel      = w_out_valid ? r_dcnt[2:1] : 2'd0;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = w_out_valid ? w_res_byte : 8'd0;
    assign bus.busy         = (r_state != ST_LOAD) && !rst;
    assign bus.done         = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_lcnt      <= 3'd0;
            r_ccnt      <= 8'd0;
            r_dcnt      <= 3'd0;
            r_mmu_start <= 1'b0;
            r_mmu_clear <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Pulse outputs are single-cycle unless re-armed below.
            r_mmu_start <= 1'b0;
            r_mmu_clear <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        // 3-bit counter wraps 7 -> 0 on the last byte.
                        r_lcnt <= r_lcnt + 3'd1;
                        if (r_lcnt == 3'd7) begin
                            r_state     <= ST_COMPUTE;
                            r_ccnt      <= 8'd0;
                            r_mmu_start <= 1'b1;
                        end
                    end
                end

                ST_COMPUTE: begin
                    r_ccnt <= r_ccnt + 8'd1;
                    if (r_ccnt == LP_CCNT_LAST) begin
                        r_state <= ST_DRAIN;
                        r_dcnt  <= 3'd0;
                    end
                end

                ST_DRAIN: begin
                    if (w_transfer) begin
                        r_dcnt <= r_dcnt + 3'd1;
                        if (r_dcnt == 3'd7) begin
                            r_state     <= ST_LOAD;
                            r_done      <= 1'b1;
                            r_mmu_clear <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_control.sv
module tb_tpu_control;
    localparam int CC = 4;

    logic clk = 1'b0;
    logic rst;

    tpu_control_if bus();

    tpu_control #(.COMPUTE_CYCLES(CC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Matrix-unit result model: four 16-bit elements selected by res_sel.
    logic [15:0] res_mem [4];
    assign bus.res_data = res_mem[bus.res_sel];

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int start_cnt = 0;
    bit pending_done = 1'b0;

    always @(posedge clk) begin
        if (bus.mmu_clear) clr_cnt <= clr_cnt + 1;
        if (bus.mmu_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_outputs(input string where);
        chk({where, ".in_ready"},     32'(bus.in_ready),     32'(0));
        chk({where, ".mem_write_en"}, 32'(bus.mem_write_en), 32'(0));
        chk({where, ".out_valid"},    32'(bus.out_valid),    32'(0));
        chk({where, ".busy"},         32'(bus.busy),         32'(0));
        chk({where, ".mem_addr"},     32'(bus.mem_addr),     32'(0));
        chk({where, ".res_sel"},      32'(bus.res_sel),      32'(0));
        chk({where, ".out_data"},     32'(bus.out_data),     32'(0));
        chk({where, ".mmu_start"},    32'(bus.mmu_start),    32'(0));
        chk({where, ".mmu_clear"},    32'(bus.mmu_clear),    32'(0));
        chk({where, ".done"},         32'(bus.done),         32'(0));
    endtask

    // Assert reset mid-cycle with in_valid/out_ready high, hold it across
    // one rising edge, then release with the host idle.
    task automatic reset_check(input string where);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        rst_outputs({where, ".rst_now"});
        @(negedge clk);
        #2;
        rst_outputs({where, ".rst_held"});
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk({where, ".rel.in_ready"}, 32'(bus.in_ready), 32'(1));
        chk({where, ".rel.mem_addr"}, 32'(bus.mem_addr), 32'(0));
        pending_done = 1'b0;
    endtask

    // One transaction. gap_mode: 0 continuous, 1 alternating, 2 random.
    // stall_mode: 0 none, 1 three-cycle stall at byte 3, 2 random.
    // rst_at: -1 none, 0..7 reset after that many bytes loaded,
    //         8..15 reset while byte (rst_at-8) is offered in drain.
    task automatic run_txn(input int gap_mode, input int stall_mode,
                           input int rst_at, input bit fixed);
        logic [7:0] bytes [8];
        logic [7:0] exp_out [8];
        logic [7:0] d;
        bit v;
        bit r;
        int idx;
        int cyc;
        int k;
        int stalls;

        for (int i = 0; i < 8; i++)
            bytes[i] = fixed ? 8'(i + 1) : 8'($urandom);
        if (fixed) begin
            res_mem[0] = 16'h1234;
            res_mem[1] = 16'h5678;
            res_mem[2] = 16'h9ABC;
            res_mem[3] = 16'hDEF0;
        end else begin
            for (int e = 0; e < 4; e++) res_mem[e] = 16'($urandom);
        end
        // Expected stream: element 0 first, low byte then high byte.
        for (int e = 0; e < 4; e++) begin
            exp_out[2*e]   = res_mem[e][7:0];
            exp_out[2*e+1] = res_mem[e][15:8];
        end

        // LOAD
        idx = 0;
        cyc = 0;
        while (idx < 8) begin
            @(negedge clk);
            case (gap_mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = (cyc > 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            endcase
            d = v ? bytes[idx] : 8'($urandom);
            bus.in_valid = v;
            bus.in_data = d;
            bus.out_ready = 1'($urandom);
            #2;
            if (rst_at == idx) begin
                reset_check("load_rst");
                return;
            end
            chk("ld.done",      32'(bus.done),      32'(cyc == 0 && pending_done));
            chk("ld.mmu_clear", 32'(bus.mmu_clear), 32'(cyc == 0 && pending_done));
            chk("ld.in_ready",  32'(bus.in_ready),  32'(1));
            chk("ld.wr_en",     32'(bus.mem_write_en), 32'(v));
            chk("ld.addr",      32'(bus.mem_addr),  32'(idx));
            chk("ld.wdata",     32'(bus.mem_in_data), 32'(d));
            chk("ld.busy",      32'(bus.busy),      32'(0));
            chk("ld.out_valid", 32'(bus.out_valid), 32'(0));
            chk("ld.out_data",  32'(bus.out_data),  32'(0));
            chk("ld.res_sel",   32'(bus.res_sel),   32'(0));
            chk("ld.mmu_start", 32'(bus.mmu_start), 32'(0));
            if (v) idx++;
            cyc++;
        end
        pending_done = 1'b0;

        // COMPUTE: host traffic must be ignored.
        for (int c = 1; c <= CC; c++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.in_data = 8'($urandom);
            bus.out_ready = 1'($urandom);
            #2;
            chk("cp.in_ready",  32'(bus.in_ready),     32'(0));
            chk("cp.wr_en",     32'(bus.mem_write_en), 32'(0));
            chk("cp.addr",      32'(bus.mem_addr),     32'(0));
            chk("cp.busy",      32'(bus.busy),         32'(1));
            chk("cp.out_valid", 32'(bus.out_valid),    32'(0));
            chk("cp.out_data",  32'(bus.out_data),     32'(0));
            chk("cp.res_sel",   32'(bus.res_sel),      32'(0));
            chk("cp.mmu_start", 32'(bus.mmu_start),    32'(c == 1));
            chk("cp.done",      32'(bus.done),         32'(0));
        end

        // DRAIN
        k = 0;
        cyc = 0;
        stalls = 0;
        while (k < 8) begin
            @(negedge clk);
            case (stall_mode)
                0: r = 1'b1;
                1: begin
                    r = !(k == 3 && stalls < 3);
                    if (!r) stalls++;
                end
                default: r = (cyc > 60) ? 1'b1 : 1'($urandom);
            endcase
            bus.out_ready = r;
            bus.in_valid = 1'($urandom);
            bus.in_data = 8'($urandom);
            #2;
            if (rst_at == 8 + k) begin
                reset_check("drain_rst");
                return;
            end
            chk("dr.out_valid", 32'(bus.out_valid),    32'(1));
            chk("dr.busy",      32'(bus.busy),         32'(1));
            chk("dr.in_ready",  32'(bus.in_ready),     32'(0));
            chk("dr.wr_en",     32'(bus.mem_write_en), 32'(0));
            chk("dr.addr",      32'(bus.mem_addr),     32'(0));
            chk("dr.res_sel",   32'(bus.res_sel),      32'(k / 2));
            chk("dr.out_data",  32'(bus.out_data),     32'(exp_out[k]));
            chk("dr.done",      32'(bus.done),         32'(0));
            chk("dr.mmu_clear", 32'(bus.mmu_clear),    32'(0));
            chk("dr.mmu_start", 32'(bus.mmu_start),    32'(0));
            if (r) k++;
            cyc++;
        end
        pending_done = 1'b1;
    endtask

    // Host idle after a finished transaction: done/mmu_clear pulse once.
    task automatic idle_done();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("id.done",      32'(bus.done),      32'(pending_done));
        chk("id.mmu_clear", 32'(bus.mmu_clear), 32'(pending_done));
        chk("id.in_ready",  32'(bus.in_ready),  32'(1));
        chk("id.busy",      32'(bus.busy),      32'(0));
        chk("id.out_valid", 32'(bus.out_valid), 32'(0));
        chk("id.addr",      32'(bus.mem_addr),  32'(0));
        @(negedge clk);
        #2;
        chk("id2.done",      32'(bus.done),      32'(0));
        chk("id2.mmu_clear", 32'(bus.mmu_clear), 32'(0));
        chk("id2.in_ready",  32'(bus.in_ready),  32'(1));
        pending_done = 1'b0;
    endtask

    initial begin
        int clr0;
        int start0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.out_ready = 1'b0;
        for (int e = 0; e < 4; e++) res_mem[e] = 16'd0;

        @(negedge clk);
        #2;
        reset_check("por");

        // Bytes 1..8, fixed results, out_ready stalled at byte 3.
        run_txn(0, 1, -1, 1'b1);
        idle_done();

        // Alternating in_valid.
        run_txn(1, 0, -1, 1'b0);
        idle_done();

        // Reset after 5 bytes, then a fresh full transaction.
        run_txn(0, 0, 5, 1'b0);
        run_txn(0, 0, -1, 1'b0);

        // Back-to-back: next load starts in the done cycle.
        clr0 = clr_cnt;
        start0 = start_cnt;
        run_txn(0, 0, -1, 1'b0);
        chk("b2b.mmu_clear_count", 32'(clr_cnt - clr0),     32'(1));
        chk("b2b.mmu_start_count", 32'(start_cnt - start0), 32'(1));
        idle_done();

        // Reset in the middle of draining.
        run_txn(2, 2, 12, 1'b0);

        // Randomized back-to-back transactions.
        for (int t = 0; t < 6; t++) run_txn(2, 2, -1, 1'b0);
        idle_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
